bit_serializer: RTL and testbench

- Upstream feeder for the serial-input sequence FSM.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single-bit serial line that drives the FSM's `in`.
- A one-word holding register keeps back-to-back words streaming with no idle cycles.
- `last` marks word boundaries for downstream framing.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/ser_hold_reg.sv | 61 ++++++
 rtl/bit_serializer.sv | 183 ++++++++++++++++++
 tb/tb_bit_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the bit serializer slice.
//   ser_state_t : serializer FSM state. PARITY is always declared but is only
//                 reachable when BIT_SERIALIZER_PARITY_EN is defined.
//   DEF_WIDTH   : default parallel word width.
//   cnt_width() : width of the bit counter for a given word width.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int DEF_WIDTH = 8;

  // Bit counter must index 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-word holding register that lets the next word wait while
// the current one is still shifting, so words stream back-to-back.
// Ports:
//   clk        input   system clock
//   reset      input   asynchronous active-high reset, empties the register
//   load       input   capture load_data and mark the register full
//   drain      input   the serializer has taken hold_data; mark empty
//   load_data  input   [WIDTH] word to capture
//   hold_data  output  [WIDTH] stored word
//   hold_full  output  register holds a word not yet taken
//   data_ready output  upstream may present a word this cycle
module ser_hold_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full,
  output logic             data_ready
);

  logic full_reg;

  // Load wins over drain: a word taken and replaced on the same edge keeps
  // the register full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  // Storage bits, each with its own load enable.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_hold_bit
      logic bit_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bit_reg <= 1'b0;
        end else if (load) begin
          bit_reg <= load_data[gi];
        end
      end
      assign hold_data[gi] = bit_reg;
    end
  endgenerate

  assign hold_full  = full_reg;
  // Held low during reset so nothing is accepted while state is being cleared.
  assign data_ready = ~full_reg & ~reset;

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: accepts parallel words over valid/ready and shifts them out
// MSB-first, one bit per clock, on a single serial line. A one-word holding
// register keeps consecutive words streaming without idle cycles.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends one even-parity
// bit after the data bits of every word (frame length WIDTH+1).
// Ports:
//   clk        input   system clock, rising edge
//   reset      input   asynchronous active-high reset
//   data_in    input   [WIDTH] parallel word, sampled on an accepting edge
//   data_valid input   producer has a word on data_in
//   data_ready output  a word can be accepted this cycle
//   out        output  serial bit
//   out_valid  output  out carries a real bit this cycle
//   last       output  out is the final bit of the current word/frame
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_reg, par_next;
`endif

  logic             accept;
  logic             word_end;
  logic             hold_load;
  logic             hold_drain;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .drain     (hold_drain),
    .load_data (data_in),
    .hold_data (hold_data),
    .hold_full (hold_full),
    .data_ready(data_ready)
  );

  assign accept = data_valid & data_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_next   = par_reg;
`endif
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    word_end   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Nothing is shifting, so an accepted word bypasses the hold register.
        if (accept) begin
          shreg_next = data_in;
          cnt_next   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_next   = 1'b0;
`endif
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        cnt_next   = cnt_reg + 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_next   = par_reg ^ shreg_reg[WIDTH-1];
`endif
        if (cnt_reg == CNT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          // Last data bit goes out; the parity cycle follows. A word arriving
          // now is mid-frame and must wait in hold.
          cnt_next   = '0;
          state_next = PARITY;
          hold_load  = accept;
`else
          word_end   = 1'b1;
`endif
        end else begin
          hold_load = accept;
        end
      end

`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        word_end = 1'b1;
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // Frame boundary: prefer the held word, then a word arriving right now,
    // otherwise go idle.
    if (word_end) begin
      cnt_next = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_next = 1'b0;
`endif
      if (hold_full) begin
        shreg_next = hold_data;
        hold_drain = 1'b1;
        hold_load  = accept;
        state_next = SHIFT;
      end else if (accept) begin
        shreg_next = data_in;
        state_next = SHIFT;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    out       = 1'b0;
    out_valid = (state_reg != IDLE);
    last      = 1'b0;
    case (state_reg)
      SHIFT: begin
        out = shreg_reg[WIDTH-1];
`ifndef BIT_SERIALIZER_PARITY_EN
        last = (cnt_reg == CNT_LAST);
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        out  = par_reg;
        last = 1'b1;
      end
`endif
      default: begin
        out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: the driver pushes the expected serial
// bits of every accepted word into a queue; a monitor pops and compares each
// valid bit on the falling edge, and flags gaps while bits are still owed.
module tb_bit_serializer;
  import serial_pkg::*;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int STALL_EXP = 8;
`else
  localparam int STALL_EXP = 7;
`endif

  typedef struct {
    logic [W-1:0] word;
    int           idx;
    logic         bit_v;
    logic         last_v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         out;
  logic         out_valid;
  logic         last;

  int checks = 0;
  int errors = 0;
  int last_wait = 0;
  logic prev_valid = 1'b0;

  bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .out       (out),
    .out_valid (out_valid),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end else begin
      $display("check %s ok: %0h", name, got);
    end
  endtask

  // Expected serial frame of one word, MSB first.
  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.word   = w;
      e.idx    = i;
      e.bit_v  = w[W-1-i];
`ifdef BIT_SERIALIZER_PARITY_EN
      e.last_v = 1'b0;
`else
      e.last_v = (i == W - 1);
`endif
      exp_q.push_back(e);
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    e.word   = w;
    e.idx    = W;
    e.bit_v  = ^w;
    e.last_v = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  // Present a word from the falling edge; it is accepted on the first rising
  // edge where data_ready is high. last_wait = falling edges spent stalled.
  task automatic send(input logic [W-1:0] w);
    int waited = 0;
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    while (!data_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    if (!data_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted after %0d cycles", w, waited);
    end else begin
      push_word(w);
      $display("send word=%h accepted after %0d stall cycles", w, waited);
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Wait for all expected bits to appear, then out_valid must drop.
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bits still owed", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check1("valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: compare every valid serial bit against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: out=%b last=%b with nothing expected", out, last);
        end else begin
          mon_e = exp_q.pop_front();
          if (out !== mon_e.bit_v || last !== mon_e.last_v) begin
            errors++;
            $display("FAIL serial_bit word=%h idx=%0d: got out=%b last=%b required out=%b last=%b",
                     mon_e.word, mon_e.idx, out, last, mon_e.bit_v, mon_e.last_v);
          end else begin
            $display("bit word=%h idx=%0d out=%b last=%b", mon_e.word, mon_e.idx, out, last);
          end
        end
      end else begin
        if (prev_valid) begin
          checks++;
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_gap: out_valid=0 with %0d bits owed", exp_q.size());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_out", {31'd0, out}, 32'd0);
    check1("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check1("rst_last", {31'd0, last}, 32'd0);
    check1("rst_ready", {31'd0, data_ready}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check1("idle_out", {31'd0, out}, 32'd0);
    check1("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check1("idle_last", {31'd0, last}, 32'd0);
    check1("idle_ready", {31'd0, data_ready}, 32'd1);

    // Single word.
    send(8'hA5);
    wait_drain();

    // Back-to-back: second word sits in hold, ready low.
    send(8'hA5);
    send(8'h3C);
    @(negedge clk);
    check1("hold_busy", {31'd0, data_ready}, 32'd0);
    wait_drain();

    // Second word arrives exactly on the end-of-word edge.
    send(8'hA5);
    repeat (7) @(posedge clk);
    send(8'h3C);
    wait_drain();

    // Three words: the third stalls until the first completes.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check1("third_stall", last_wait, STALL_EXP);
    wait_drain();

    // Reset mid-word with hold full.
    send(8'hF0);
    send(8'h55);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check1("mid_rst_out", {31'd0, out}, 32'd0);
    check1("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check1("mid_rst_last", {31'd0, last}, 32'd0);
    check1("mid_rst_ready", {31'd0, data_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check1("post_rst_ready", {31'd0, data_ready}, 32'd1);
    check1("post_rst_valid", {31'd0, out_valid}, 32'd0);
    send(8'h81);
    wait_drain();

    // Parity vectors (plain 8-bit frames when parity is not compiled in).
    send(8'hA5);
    wait_drain();
    send(8'h01);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
